// File: rtl/bcd_seq_pkg.sv
// Shared types and widths for the BCD digit sequencer and its helpers.
package bcd_seq_pkg;

    localparam int unsigned BCD_W   = 4;
    localparam int unsigned BCD_MAX = 9;
    localparam int unsigned XFER_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_step.sv
// Combinational next BCD digit, up or down, wrapping 9<->0.
module bcd_step
    import bcd_seq_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    input  logic             down,
    output logic [BCD_W-1:0] next
);

    // Step by one inside 0..9; out-of-range inputs fold back to 0 going up.
    always_comb begin
        next = digit;
        if (down) begin
            next = (digit == '0) ? BCD_W'(BCD_MAX) : digit - BCD_W'(1);
        end else begin
            next = (digit >= BCD_W'(BCD_MAX)) ? '0 : digit + BCD_W'(1);
        end
    end

endmodule

// File: rtl/bcd_digit_sequencer.sv
// Programmable BCD digit source with dwell time and valid/ready handshake.
module bcd_digit_sequencer
    import bcd_seq_pkg::*;
#(
    parameter int unsigned START_DIGIT = 0,
    parameter int unsigned END_DIGIT   = 9,
    parameter int unsigned REPEAT      = 1,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              dir_down,
    input  logic              ready,
    output logic              a,
    output logic              b,
    output logic              c,
    output logic              d,
    output logic              valid,
    output logic              busy,
    output logic              done,
    output logic [XFER_W-1:0] xfer_count
);

    localparam int unsigned PASS_W  = (REPEAT > 1) ? $clog2(REPEAT) : 1;
    localparam int unsigned DWELL_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [BCD_W-1:0]   START_BCD = BCD_W'(START_DIGIT);
    localparam logic [BCD_W-1:0]   END_BCD   = BCD_W'(END_DIGIT);
    localparam logic [PASS_W-1:0]  LAST_PASS = PASS_W'(REPEAT - 1);
    localparam logic [DWELL_W-1:0] DWELL_TOP = DWELL_W'(HOLD_CYCLES - 1);

    // Reject parameter sets that could drive a non-BCD code or never finish.
    if (START_DIGIT > BCD_MAX) begin : g_bad_start
        $error("START_DIGIT must be 0..9");
    end
    if (END_DIGIT > BCD_MAX) begin : g_bad_end
        $error("END_DIGIT must be 0..9");
    end
    if (REPEAT == 0) begin : g_bad_repeat
        $error("REPEAT must be >= 1");
    end
    if (HOLD_CYCLES == 0) begin : g_bad_hold
        $error("HOLD_CYCLES must be >= 1");
    end

    state_t              state;
    logic [BCD_W-1:0]    digit;
    logic [BCD_W-1:0]    next_digit;
    logic [PASS_W-1:0]   pass;
    logic [DWELL_W-1:0]  dwell;
    logic                down;

    bcd_step u_step (
        .digit (digit),
        .down  (down),
        .next  (next_digit)
    );

    assign a = digit[3];
    assign b = digit[2];
    assign c = digit[1];
    assign d = digit[0];

    // Sequencer FSM: start/abort control, dwell countdown, handshake advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            digit      <= START_BCD;
            valid      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            xfer_count <= '0;
            pass       <= '0;
            dwell      <= '0;
            down       <= 1'b0;
        end else if (abort) begin
            state <= IDLE;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= RUN;
                        digit      <= START_BCD;
                        valid      <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        xfer_count <= '0;
                        pass       <= '0;
                        dwell      <= DWELL_TOP;
                        down       <= dir_down;
                    end
                end
                RUN: begin
                    if (dwell != '0) begin
                        dwell <= dwell - DWELL_W'(1);
                    end else if (ready) begin
                        xfer_count <= xfer_count + XFER_W'(1);
                        if (digit == END_BCD && pass == LAST_PASS) begin
                            state <= DONE;
                            valid <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else if (digit == END_BCD) begin
                            pass  <= pass + PASS_W'(1);
                            digit <= START_BCD;
                            dwell <= DWELL_TOP;
                        end else begin
                            digit <= next_digit;
                            dwell <= DWELL_TOP;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/bcd_digit_sequencer.md
Name: bcd_digit_sequencer

Overview:
Clocked BCD stimulus source that sits directly upstream of the team's combinational BCD-to-excess-3 converter stage. It drives that stage's four digit inputs a (MSB), b, c, d. It steps through a programmable range of BCD digits, up or down, for a set number of passes. Each digit is held for a minimum dwell time and is advanced only under a valid/ready handshake with the consumer.

Parameters:
START_DIGIT, 0, first digit of each pass; must be 0..9; elaboration error otherwise
END_DIGIT, 9, last digit of each pass; must be 0..9; elaboration error otherwise
REPEAT, 1, number of full passes before done; must be >= 1
HOLD_CYCLES, 4, minimum cycles each digit is presented; must be >= 1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
start  input  1  one-cycle request to begin a sequence
abort  input  1  synchronous cancel of the running sequence
dir_down  input  1  0 = count up, 1 = count down; sampled only on accepted start
ready  input  1  consumer accepts the current digit
a  output  1  digit bit 3 (MSB)
b  output  1  digit bit 2
c  output  1  digit bit 1
d  output  1  digit bit 0 (LSB)
valid  output  1  {a,b,c,d} holds a digit to be consumed
busy  output  1  high in RUN
done  output  1  sequence completed; held until next start or rst
xfer_count  output  8  number of accepted digits since last start; wraps 255->0

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst). rst overrides all other inputs.
- Reset values: state = IDLE; {a,b,c,d} = START_DIGIT; valid = 0; busy = 0; done = 0; xfer_count = 0; pass and dwell counters = 0.
- States: IDLE, RUN, DONE. All outputs are registered; there are no combinational paths from inputs to outputs.
- IDLE or DONE, start=1, abort=0:
  - Next cycle: state RUN, digit = START_DIGIT, valid = 1, busy = 1, done = 0, xfer_count = 0, pass = 0.
  - dwell = HOLD_CYCLES-1; dir_down is latched.
- RUN, dwell:
  - If dwell != 0: dwell decrements by 1 and the digit is unchanged.
  - valid stays high throughout RUN.
- RUN, acceptance: a transfer occurs when dwell == 0 and ready == 1.
  - xfer_count increments.
  - If the digit is END_DIGIT and pass == REPEAT-1: next state DONE, valid = 0, busy = 0, done = 1, digit holds its last value.
  - Else if the digit is END_DIGIT: pass increments, digit = START_DIGIT, dwell reloads.
  - Else: digit = next value (up: +1, 9 wraps to 0; down: -1, 0 wraps to 9), dwell reloads.
- RUN, stall: if dwell == 0 and ready == 0, digit and valid are held indefinitely. There is no timeout.
- Range wrap: the range may wrap. Example: START=7, END=2, up gives 7,8,9,0,1,2.
  - If START == END, each pass is a single digit.
- Digit range: the digit never leaves 0..9. Codes 10..15 are never driven.
- HOLD_CYCLES = 1: one transfer per cycle while ready is held high.
- start while RUN: ignored. dir_down changes while RUN: ignored.
- abort=1 in any state: next cycle IDLE, valid = 0, busy = 0, done = 0. The digit and xfer_count keep their current values.
- abort and start in the same cycle: abort wins.
- rst mid-sequence: returns to the reset values on the next edge; no transfer completes on that edge.

Decomposition:
- Package bcd_seq_pkg:
  - state enum {IDLE, RUN, DONE}
  - BCD_W = 4, BCD_MAX = 9, XFER_W = 8
- Sub-module bcd_step: combinational next-digit function. Inputs digit[3:0] and down; output next[3:0] with 0/9 wrap. It is reused by later counter stages.

Test Plan:
1. Defaults, ready tied high, start pulse with dir_down=0:
   - digits 0..9 each held for exactly 4 cycles with valid=1;
   - done rises one cycle after the 10th transfer;
   - xfer_count=10; {a,b,c,d}=4'b1001 at done.
2. START=7, END=2, REPEAT=2, HOLD=1, dir_down=1:
   - sequence 7,6,5,4,3,2,7,6,5,4,3,2;
   - xfer_count=12, then done.
3. ready deasserted for 6 cycles while digit=3 with dwell expired:
   - digit stays 3 and valid stays 1;
   - advances to 4 on the first cycle after ready returns.
4. abort asserted at digit=5, together with start:
   - next cycle state IDLE, valid=0, busy=0, digit=5;
   - a later start restarts at 0 with xfer_count=0.
5. rst asserted mid-RUN at digit=6:
   - next cycle all outputs at reset values ({a,b,c,d}=0, valid=0).
6. start pulsed again while RUN, and in DONE:
   - ignored in RUN (sequence unaffected);
   - in DONE, restarts with done=0 next cycle.
